// File: rtl/tappu_pkg.sv
// Shared types and sizing for the tappu MAC job sequencer.
package tappu_pkg;

    // Ceiling log2 for constant sizing; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

    localparam int unsigned N     = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned ACC_W = 20;
    localparam int unsigned OB    = (ACC_W + 7) / 8;
    localparam int unsigned PAD_W = OB * 8;
    localparam int unsigned AW    = (clog2(N) == 0) ? 1 : clog2(N);
    localparam int unsigned CW    = clog2(N + 1);
    localparam int unsigned OBW   = (clog2(OB) == 0) ? 1 : clog2(OB);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        LOAD_A  = 3'd2,
        COMPUTE = 3'd3,
        DRAIN   = 3'd4
    } state_t;

endpackage

// File: rtl/tappu_byte_serializer.sv
// Streams an ACC_W-bit word out as OB bytes, LSB byte first, over valid/ready.
// The word is sliced live; the caller keeps it stable while draining.
module tappu_byte_serializer
    import tappu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [ACC_W-1:0] word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             last
);

    logic               active_q;
    logic [OBW-1:0]     b_q;
    logic [OB-1:0][7:0] bytes;

    assign bytes     = PAD_W'(word);
    assign out_valid = active_q;
    assign out_data  = active_q ? bytes[b_q] : 8'h00;
    assign last      = active_q && out_ready && (b_q == OBW'(OB - 1));

    // Byte index and activity flag; clr cancels an in-progress drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            b_q      <= '0;
        end else if (clr) begin
            active_q <= 1'b0;
            b_q      <= '0;
        end else if (load) begin
            active_q <= 1'b1;
            b_q      <= '0;
        end else if (active_q && out_ready) begin
            if (b_q == OBW'(OB - 1)) begin
                active_q <= 1'b0;
                b_q      <= '0;
            end else begin
                b_q <= b_q + OBW'(1);
            end
        end
    end

endmodule

// File: rtl/tappu_mac_sequencer.sv
// Sequences one N-element dot-product job: load weights, load activations,
// step the MAC through N products, then drain the accumulator as bytes.
module tappu_mac_sequencer
    import tappu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic             buf_we,
    output logic             buf_sel,
    output logic [AW-1:0]    buf_addr,
    output logic [DW-1:0]    buf_wdata,
    output logic             mac_clr,
    output logic             mac_en,
    input  logic [ACC_W-1:0] acc_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             busy,
    output logic             done
);

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mac_en_q, mac_en_d;
    logic            done_q, done_d;
    logic            ser_load;
    logic            ser_clr;
    logic            ser_last;

    assign buf_wdata = in_ready ? in_data : '0;
    assign busy      = (state_q != IDLE);
    assign mac_en    = mac_en_q;
    assign done      = done_q;

    // State, counters and the delayed accumulate strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            mac_en_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            mac_en_q <= mac_en_d;
            done_q   <= done_d;
        end
    end

    // Next-state and handshake/buffer controls; abort overrides everything.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        mac_en_d = 1'b0;
        done_d   = 1'b0;
        in_ready = 1'b0;
        buf_we   = 1'b0;
        buf_sel  = 1'b0;
        buf_addr = '0;
        mac_clr  = 1'b0;
        ser_load = 1'b0;
        ser_clr  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_W;
                    idx_d   = '0;
                end
            end
            LOAD_W, LOAD_A: begin
                in_ready = 1'b1;
                buf_sel  = (state_q == LOAD_A);
                buf_addr = idx_q;
                if (in_valid) begin
                    buf_we = 1'b1;
                    if (idx_q == AW'(N - 1)) begin
                        idx_d   = '0;
                        cnt_d   = '0;
                        state_d = (state_q == LOAD_W) ? LOAD_A : COMPUTE;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            COMPUTE: begin
                // Reads issue on cycles 0..N-1; the product lands one cycle later.
                mac_clr = (cnt_q == '0);
                if (cnt_q < CW'(N)) begin
                    buf_addr = cnt_q[AW-1:0];
                    mac_en_d = 1'b1;
                    cnt_d    = cnt_q + CW'(1);
                end else begin
                    cnt_d    = '0;
                    ser_load = 1'b1;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                if (ser_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d  = IDLE;
            idx_d    = '0;
            cnt_d    = '0;
            mac_en_d = 1'b0;
            done_d   = 1'b0;
            in_ready = 1'b0;
            buf_we   = 1'b0;
            mac_clr  = 1'b0;
            ser_load = 1'b0;
            ser_clr  = 1'b1;
        end
    end

    tappu_byte_serializer u_ser (
        .clk       (clk),
        .rst       (rst),
        .clr       (ser_clr),
        .load      (ser_load),
        .word      (acc_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .last      (ser_last)
    );

endmodule
